// File: rtl/alu_seq_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_seq_ctrl_pkg                                               |
// | Desc     : ALU op codes, sequencer command/state encodings, MUL constants |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_GTR = 3'd5,
    ALU_SRL = 3'd6,
    ALU_SLL = 3'd7
  } ALU_Ops;

  typedef enum logic {
    SEQ_SINGLE = 1'b0,
    SEQ_MUL    = 1'b1
  } SeqCmd;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SGL   = 3'd1,
    S_ADD   = 3'd2,
    S_CARRY = 3'd3,
    S_SHHI  = 3'd4,
    S_SHLO  = 3'd5,
    S_DONE  = 3'd6
  } SeqState;

  localparam int MUL_ITERS = 8;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu                                                            |
// | Desc     : Shared 8-bit combinational ALU; zero_out reflects the full     |
// |            precision result, so a wrapped ADD does not report zero.       |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu
  import alu_seq_ctrl_pkg::*;
(
  input  logic [3:0] op_ctrl,
  input  logic [7:0] reg_in,
  input  logic [7:0] acc_in,
  output logic [7:0] rslt_out,
  output logic       zero_out
);

  logic [8:0] w_full;

  always_comb begin
    w_full = 9'd0;
    case (op_ctrl)
      {1'b0, ALU_ADD}: w_full = {1'b0, acc_in} + {1'b0, reg_in};
      {1'b0, ALU_SUB}: w_full = {1'b0, acc_in} - {1'b0, reg_in};
      {1'b0, ALU_AND}: w_full = {1'b0, acc_in & reg_in};
      {1'b0, ALU_OR }: w_full = {1'b0, acc_in | reg_in};
      {1'b0, ALU_XOR}: w_full = {1'b0, acc_in ^ reg_in};
      {1'b0, ALU_GTR}: w_full = {8'd0, reg_in > acc_in};
      {1'b0, ALU_SRL}: w_full = {1'b0, acc_in >> reg_in};
      {1'b0, ALU_SLL}: w_full = {1'b0, acc_in << reg_in};
      default:         w_full = 9'd0;
    endcase
  end

  assign rslt_out = w_full[7:0];
  assign zero_out = (w_full == 9'd0);

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : alu_seq_ctrl                                                   |
// | Desc     : Multi-cycle sequencer driving the shared ALU: single op or     |
// |            8x8 shift-add multiply. Option: ALU_SEQ_ZERO_SKIP_EN.          |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cmd,
  input  logic [2:0] single_op,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  output logic [2:0] alu_op,
  output logic [7:0] alu_reg,
  output logic [7:0] alu_acc,
  input  logic [7:0] alu_rslt,
  input  logic       alu_zero,
  output logic       busy,
  output logic       done,
  output logic [7:0] rslt_hi,
  output logic [7:0] rslt_lo,
  output logic       zero_flag
);

  SeqState    r_state;
  SeqState    w_next;
  SeqCmd      w_cmd;
  logic       w_skip;
  logic       w_last;
  logic [7:0] w_lo_next;

  logic [7:0] r_mcand;
  logic [7:0] r_lo;
  logic [7:0] r_hi;
  logic [7:0] r_tmp;
  logic [3:0] r_cnt;
  logic       r_c;
  logic       r_hb;
  logic [7:0] r_rslt_hi;
  logic [7:0] r_rslt_lo;
  logic       r_zero;

  assign w_cmd     = SeqCmd'(cmd);
  assign w_last    = (r_cnt == 4'(MUL_ITERS - 1));
  assign w_lo_next = {r_hb, alu_rslt[6:0]};

`ifdef ALU_SEQ_ZERO_SKIP_EN
  assign w_skip = (w_cmd == SEQ_MUL) && ((opa == 8'd0) || (opb == 8'd0));
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    alu_op  = ALU_ADD;
    alu_reg = 8'd0;
    alu_acc = 8'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_skip)                  w_next = S_DONE;
          else if (w_cmd == SEQ_SINGLE) w_next = S_SGL;
          else if (opb[0])             w_next = S_ADD;
          else                         w_next = S_SHHI;
        end
      end
      S_SGL: begin
        alu_op  = single_op;
        alu_reg = r_lo;
        alu_acc = r_mcand;
        w_next  = S_DONE;
      end
      S_ADD: begin
        alu_op  = ALU_ADD;
        alu_reg = r_hi;
        alu_acc = r_mcand;
        w_next  = S_CARRY;
      end
      S_CARRY: begin
        // Carry out of hi+mcand is exactly "old hi > wrapped sum".
        alu_op  = ALU_GTR;
        alu_reg = r_hi;
        alu_acc = r_tmp;
        w_next  = S_SHHI;
      end
      S_SHHI: begin
        alu_op  = ALU_SRL;
        alu_reg = 8'd1;
        alu_acc = r_hi;
        w_next  = S_SHLO;
      end
      S_SHLO: begin
        alu_op  = ALU_SRL;
        alu_reg = 8'd1;
        alu_acc = r_lo;
        if (w_last)           w_next = S_DONE;
        else if (alu_rslt[0]) w_next = S_ADD;
        else                  w_next = S_SHHI;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Result registers load on the edge entering DONE so they are valid with done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcand   <= 8'd0;
      r_lo      <= 8'd0;
      r_hi      <= 8'd0;
      r_tmp     <= 8'd0;
      r_cnt     <= 4'd0;
      r_c       <= 1'b0;
      r_hb      <= 1'b0;
      r_rslt_hi <= 8'd0;
      r_rslt_lo <= 8'd0;
      r_zero    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand <= opa;
            r_lo    <= opb;
            r_hi    <= 8'd0;
            r_cnt   <= 4'd0;
            r_c     <= 1'b0;
            if (w_skip) begin
              r_rslt_hi <= 8'd0;
              r_rslt_lo <= 8'd0;
              r_zero    <= 1'b0;
            end
          end
        end
        S_SGL: begin
          r_rslt_lo <= alu_rslt;
          r_rslt_hi <= 8'd0;
          r_zero    <= alu_zero;
        end
        S_ADD: r_tmp <= alu_rslt;
        S_CARRY: begin
          r_c  <= alu_rslt[0];
          r_hi <= r_tmp;
        end
        S_SHHI: begin
          r_hi <= {r_c, alu_rslt[6:0]};
          r_hb <= r_hi[0];
          r_c  <= 1'b0;
        end
        S_SHLO: begin
          r_lo  <= w_lo_next;
          r_cnt <= r_cnt + 4'd1;
          if (w_last) begin
            r_rslt_hi <= r_hi;
            r_rslt_lo <= w_lo_next;
            r_zero    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign rslt_hi   = r_rslt_hi;
  assign rslt_lo   = r_rslt_lo;
  assign zero_flag = r_zero;

endmodule
`default_nettype wire
